delay_measure_unit: RTL and testbench

//  Loop-back latency meter: the probing end of a delay path such as DELAY_UNIT.
//  On request it launches a 1-cycle probe pulse into the path and waits for the

---
 rtl/delay_measure_unit.sv | 174 +++++++++++++++++
 tb/tb_delay_measure_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_measure_unit.sv
// Loop-back latency meter: fires a 1-cycle probe into a delay path and times the echo.
// Optional build macro DELAY_MEAS_AVG_EN averages four back-to-back rounds per request.
module delay_measure_unit #(
    parameter int unsigned P_CNT_WIDTH = 8,
    parameter int unsigned P_TIMEOUT   = 200
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_probe,
    input  logic                   i_echo,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout,
    output logic [P_CNT_WIDTH-1:0] o_delay_cnt
);

    localparam int unsigned CW = P_CNT_WIDTH;
    localparam logic [CW-1:0] CNT_TIMEOUT = CW'(P_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          echo_q, echo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] res_q, res_d;
    logic          tmo_q, tmo_d;
    logic          probe_q, probe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] delay_q, delay_d;
    logic          echo_edge;

`ifdef DELAY_MEAS_AVG_EN
    logic [1:0]    round_q, round_d;
    logic [CW+1:0] sum_q, sum_d;
    logic [CW+1:0] sum_nxt;
`endif

    assign echo_edge = i_echo & ~echo_q;

    // Next-state, counter and result logic
    always_comb begin
        state_d   = state_q;
        echo_d    = i_echo;
        cnt_d     = cnt_q;
        res_d     = res_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        delay_d   = delay_q;
`ifdef DELAY_MEAS_AVG_EN
        round_d   = round_q;
        sum_d     = sum_q;
        sum_nxt   = sum_q + (CW+2)'(res_q);
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_PROBE;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
`ifdef DELAY_MEAS_AVG_EN
                    round_d = 2'd0;
                    sum_d   = '0;
`endif
                end
            end
            S_PROBE: begin
                if (echo_edge) begin
                    state_d = S_DONE;
                    res_d   = '0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT: begin
                // Timeout compare precedes the increment so the counter never wraps
                if (echo_edge) begin
                    state_d = S_DONE;
                    res_d   = cnt_q;
                end else if (cnt_q == CNT_TIMEOUT) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                    res_d   = '1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
`ifdef DELAY_MEAS_AVG_EN
                if (tmo_q) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    delay_d   = '1;
                end else if (round_q == 2'd3) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    delay_d = CW'(sum_nxt >> 2);
                end else begin
                    state_d = S_PROBE;
                    cnt_d   = '0;
                    round_d = round_q + 2'd1;
                    sum_d   = sum_nxt;
                end
`else
                state_d   = S_IDLE;
                done_d    = 1'b1;
                timeout_d = tmo_q;
                delay_d   = res_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        probe_d = (state_d == S_PROBE);
        busy_d  = (state_d == S_PROBE) || (state_d == S_WAIT);
`ifdef DELAY_MEAS_AVG_EN
        // Stay busy through the DONE cycles that separate rounds
        if ((state_d == S_DONE) && !tmo_d && (round_d != 2'd3))
            busy_d = 1'b1;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            echo_q    <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            tmo_q     <= 1'b0;
            probe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            delay_q   <= '0;
`ifdef DELAY_MEAS_AVG_EN
            round_q   <= 2'd0;
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            echo_q    <= echo_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            tmo_q     <= tmo_d;
            probe_q   <= probe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            delay_q   <= delay_d;
`ifdef DELAY_MEAS_AVG_EN
            round_q   <= round_d;
            sum_q     <= sum_d;
`endif
        end
    end

    assign o_probe     = probe_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_delay_cnt = delay_q;

endmodule

// File: tb/tb_delay_measure_unit.sv
// Directed bench for delay_measure_unit: behavioural delay line in the loop, scoreboard of results.
module tb_delay_measure_unit;

    localparam int unsigned CW = 8;
    localparam int unsigned TO = 20;

    typedef struct {
        int delay;
        int tmo;
        int lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          probe;
    logic          echo;
    logic          busy;
    logic          done;
    logic          tmo;
    logic [CW-1:0] dcnt;

    int            mode = 1;     // 0: combinational loop-back, 1: D-stage line, 2: tied low
    int            d_sel = 0;
    logic [15:0]   sh = '0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    exp_t          sb[$];

    delay_measure_unit #(.P_CNT_WIDTH(CW), .P_TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_probe     (probe),
        .i_echo      (echo),
        .o_busy      (busy),
        .o_done      (done),
        .o_timeout   (tmo),
        .o_delay_cnt (dcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sh  <= {sh[14:0], probe};
    end

    always_comb begin
        case (mode)
            0:       echo = probe;
            1:       echo = (d_sel == 0) ? probe : sh[d_sel-1];
            default: echo = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    // Issue one request, optionally poke i_start during WAIT, then score the result
    task automatic measure(input string tag, input int exp_d, input int exp_to,
                           input int exp_lat, input int pokes);
        exp_t e;
        int   pc;
        int   extra;
        bit   seen;
        e.delay = exp_d;
        e.tmo   = exp_to;
        e.lat   = exp_lat;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        pc = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (probe) begin
                seen = 1'b1;
                pc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, "_probe_seen"}, int'(seen), 1);
        chk({tag, "_busy"}, int'(busy), 1);
        for (int p = 0; p < pokes; p++) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_delay"}, int'(dcnt), e.delay);
            chk({tag, "_timeout"}, int'(tmo), e.tmo);
            if (e.lat >= 0) chk({tag, "_latency"}, cyc - pc, e.lat);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({tag, "_single_done"}, extra, 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_held"}, int'(dcnt), exp_d);
    endtask

    initial begin
        #12;
        chk("rst_probe", int'(probe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(tmo), 0);
        chk("rst_cnt", int'(dcnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef DELAY_MEAS_AVG_EN
        mode = 0;
        measure("loopback", 0, 0, 2, 0);
        mode = 1; d_sel = 2;
        measure("d2", 2, 0, 4, 0);
        mode = 1; d_sel = 1;
        measure("d1", 1, 0, 3, 0);
        mode = 2;
        measure("timeout", 255, 1, TO + 2, 0);
        mode = 1; d_sel = 5;
        measure("pokes_d5", 5, 0, 7, 2);

        // Reset in the middle of WAIT aborts silently
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_probe", int'(probe), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_timeout", int'(tmo), 0);
        chk("mid_rst_cnt", int'(dcnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int nd;
            nd = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("mid_rst_no_done", nd, 0);
        end
        measure("after_rst_d5", 5, 0, 7, 0);
        mode = 1; d_sel = 13;
        measure("d13", 13, 0, 15, 0);
`else
        // Four rounds with delays 3,3,4,4 -> floor(14/4) = 3
        begin
            int dl[4];
            int k;
            int nd;
            int busy_low;
            bit fin;
            dl[0] = 3; dl[1] = 3; dl[2] = 4; dl[3] = 4;
            mode = 1; d_sel = dl[0];
            k = 0; nd = 0; busy_low = 0; fin = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 200 && !fin; i++) begin
                if (probe) begin
                    d_sel = dl[k];
                    k++;
                end
                if (done) begin
                    nd++;
                    fin = 1'b1;
                    chk("avg_delay", int'(dcnt), 3);
                    chk("avg_timeout", int'(tmo), 0);
                end else if (!busy && k > 0) begin
                    busy_low++;
                end
                if (!fin) @(negedge clk);
            end
            chk("avg_done_seen", int'(fin), 1);
            chk("avg_rounds", k, 4);
            chk("avg_busy_gaps", busy_low, 1);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("avg_single_done", nd, 1);
        end
        mode = 2;
        measure("avg_timeout", 255, 1, -1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
